// File: rtl/hex_word_ascii_streamer.sv
// Streams a NIBBLES-digit hex word as uppercase ASCII characters, most significant digit first.
// Optional trailing CR/LF per word when HEX_STREAM_CRLF_EN is defined.
module hex_word_ascii_streamer #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic [4*NIBBLES-1:0] in_data,
  output logic                 in_ready,
  output logic                 out_valid,
  output logic [6:0]           out_char,
  input  logic                 out_ready,
  output logic                 busy
);

  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIBBLES - 1);

`ifdef HEX_STREAM_CRLF_EN
  typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, CR = 2'd2, LF = 2'd3} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1} state_t;
`endif

  state_t               state_r;
  logic [IDX_W-1:0]     idx_r;
  logic [4*NIBBLES-1:0] word_r;
  logic                 out_valid_r;
  logic [6:0]           out_char_r;
  logic                 busy_r;
  logic                 in_ready_r;

  function automatic logic [6:0] hex_ascii(input logic [3:0] n);
    logic [6:0] c;
    if (n < 4'd10) begin
      c = 7'h30 + {3'b000, n};
    end else begin
      c = 7'h37 + {3'b000, n};  // 0x41 + (n - 10)
    end
    return c;
  endfunction

  function automatic logic [3:0] nibble_at(input logic [4*NIBBLES-1:0] w,
                                           input logic [IDX_W-1:0] i);
    logic [4*NIBBLES-1:0] sh;
    sh = w >> {i, 2'b00};
    return sh[3:0];
  endfunction

  // Stream state machine; every output is a register updated alongside the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      idx_r       <= '0;
      word_r      <= '0;
      out_valid_r <= 1'b0;
      out_char_r  <= 7'h00;
      busy_r      <= 1'b0;
      in_ready_r  <= 1'b1;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid && in_ready_r) begin
            word_r      <= in_data;
            idx_r       <= IDX_LAST;
            out_char_r  <= hex_ascii(in_data[4*NIBBLES-1 -: 4]);
            out_valid_r <= 1'b1;
            busy_r      <= 1'b1;
            in_ready_r  <= 1'b0;
            state_r     <= SEND;
          end else begin
            state_r <= IDLE;
          end
        end
        SEND: begin
          if (out_ready) begin
            if (idx_r == '0) begin
`ifdef HEX_STREAM_CRLF_EN
              out_char_r <= 7'h0D;
              state_r    <= CR;
`else
              out_char_r  <= 7'h00;
              out_valid_r <= 1'b0;
              busy_r      <= 1'b0;
              in_ready_r  <= 1'b1;
              state_r     <= IDLE;
`endif
            end else begin
              idx_r      <= idx_r - IDX_ONE;
              out_char_r <= hex_ascii(nibble_at(word_r, idx_r - IDX_ONE));
            end
          end else begin
            state_r <= SEND;
          end
        end
`ifdef HEX_STREAM_CRLF_EN
        CR: begin
          if (out_ready) begin
            out_char_r <= 7'h0A;
            state_r    <= LF;
          end else begin
            state_r <= CR;
          end
        end
        LF: begin
          if (out_ready) begin
            out_char_r  <= 7'h00;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            in_ready_r  <= 1'b1;
            state_r     <= IDLE;
          end else begin
            state_r <= LF;
          end
        end
`endif
        default: begin
          idx_r       <= '0;
          out_char_r  <= 7'h00;
          out_valid_r <= 1'b0;
          busy_r      <= 1'b0;
          in_ready_r  <= 1'b1;
          state_r     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_char  = out_char_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_hex_word_ascii_streamer.sv
// Scoreboard bench for hex_word_ascii_streamer (NIBBLES=4); follows HEX_STREAM_CRLF_EN if defined.
module tb_hex_word_ascii_streamer;

  localparam int N = 4;

  logic           clk;
  logic           rst_n;
  logic           in_valid;
  logic [4*N-1:0] in_data;
  logic           in_ready;
  logic           out_valid;
  logic [6:0]     out_char;
  logic           out_ready;
  logic           busy;

  int total;
  int bad;
  logic [6:0] exp_q[$];
  logic       hold_pending;
  logic [6:0] held_c;

  hex_word_ascii_streamer #(.NIBBLES(N)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_char(out_char),
    .out_ready(out_ready), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [6:0] exp_char(input logic [3:0] n);
    if (n <= 4'd9) return 7'h30 + 7'(n);
    else return 7'h41 + 7'(n - 4'd10);
  endfunction

  // Offer one word at a falling edge once in_ready is seen, queue its expected characters.
  task automatic send_word(input logic [4*N-1:0] w);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check_val("accept_wait", in_ready, 1);
    in_valid = 1'b1;
    in_data  = w;
    for (int i = N - 1; i >= 0; i--) exp_q.push_back(exp_char(w[4*i +: 4]));
`ifdef HEX_STREAM_CRLF_EN
    exp_q.push_back(7'h0D);
    exp_q.push_back(7'h0A);
`endif
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check_val("first_valid", out_valid, 1);
    check_val("first_char", out_char, exp_char(w[4*N-1 -: 4]));
  endtask

  // Wait for the word to finish and the queue to empty, then check the IDLE outputs.
  task automatic drain();
    int guard;
    guard = 0;
    @(negedge clk);
    while ((busy || exp_q.size() != 0) && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check_val("drain_busy", busy, 0);
    check_val("drain_q", 32'(exp_q.size()), 0);
    check_val("idle_ready", in_ready, 1);
    check_val("idle_valid", out_valid, 0);
    check_val("idle_char", out_char, 0);
  endtask

  // Scoreboard monitor plus stall-stability check, sampled on the falling edge.
  always @(negedge clk) begin
    if (rst_n && hold_pending)
      check_val("hold", {25'd0, out_valid, out_char}, {25'd0, 1'b1, held_c});
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check_val("sb_empty", 32'(exp_q.size()), 1);
      end else begin
        check_val("char", out_char, exp_q.pop_front());
      end
    end
    hold_pending <= rst_n && out_valid && !out_ready;
    held_c       <= out_char;
  end

  initial begin
    logic [4*N-1:0] w;
    int guard;
    total = 0;
    bad = 0;
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    out_ready = 1'b1;
    hold_pending = 1'b0;
    #12;
    check_val("rst_ready", in_ready, 1);
    check_val("rst_valid", out_valid, 0);
    check_val("rst_char", out_char, 0);
    check_val("rst_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic word, then back-to-back extremes and a CR/LF-style word.
    send_word(16'h1A2F);
    drain();
    send_word(16'h0000);
    send_word(16'hFFFF);
    drain();
    send_word(16'h00AB);
    drain();

    // Stall during the second character.
    send_word(16'h9B3C);
    @(posedge clk);
    #1;
    check_val("bp_char", out_char, 7'h42);
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_val("bp_still", out_char, 7'h42);
    out_ready = 1'b1;
    drain();

    // in_valid while streaming must be ignored.
    send_word(16'h1234);
    in_valid = 1'b1;
    in_data  = 16'h5555;
    repeat (3) begin
      @(posedge clk);
      #1;
      check_val("busy_ignore", busy, 1);
    end
    in_valid = 1'b0;
    drain();

    // Reset mid-word abandons the rest.
    send_word(16'h1234);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_val("ar_valid", out_valid, 0);
    check_val("ar_char", out_char, 0);
    check_val("ar_busy", busy, 0);
    check_val("ar_ready", in_ready, 1);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check_val("post_rst_valid", out_valid, 0);
    end
    check_val("post_rst_ready", in_ready, 1);

    // Random words with random backpressure.
    for (int k = 0; k < 6; k++) begin
      w = 16'($urandom);
      send_word(w);
      guard = 0;
      while (busy && guard < 200) begin
        @(posedge clk);
        #1;
        out_ready = 1'($urandom_range(0, 1));
        guard++;
      end
      out_ready = 1'b1;
      drain();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hex_word_ascii_streamer.md
HEX_WORD_ASCII_STREAMER -- requirements
Module: hex_word_ascii_streamer

Interface
REQ-001 SHALL have parameter NIBBLES, default 4, meaning the number of hex digits per input word (legal range 1..8).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port in_valid, input, 1 bit: in_data is offered.
REQ-005 SHALL have port in_data, input, 4*NIBBLES bits: hex word to print, most significant nibble first.
REQ-006 SHALL have port in_ready, output, 1 bit: block accepts a word this cycle.
REQ-007 SHALL have port out_valid, output, 1 bit: out_char holds a valid character.
REQ-008 SHALL have port out_char, output, 7 bits: ASCII character code.
REQ-009 SHALL have port out_ready, input, 1 bit: consumer takes out_char this cycle.
REQ-010 SHALL have port busy, output, 1 bit: a word is being streamed (state not IDLE).

Function
REQ-011 SHALL implement states IDLE, SEND, and (with REQ-025) CR and LF; no other states.
REQ-012 SHALL drive in_ready = 1 only in IDLE; word accepted when in_valid && in_ready.
REQ-013 On accept: capture in_data into a word register, set nibble index to NIBBLES-1, next state SEND.
REQ-014 In SEND: out_valid = 1; out_char = ASCII of captured nibble at current index.
REQ-015 Encoding SHALL be: nibble 0-9 -> 0x30+n; nibble 10-15 -> 0x41+(n-10), uppercase only; bit 7 never produced.
REQ-016 Latency: first character valid in the cycle after the accept edge; no combinational path from in_data to out_char.
REQ-017 Character transfer occurs when out_valid && out_ready; index then decrements by one on that edge.
REQ-018 While out_valid && !out_ready, out_char and out_valid SHALL hold stable; no character skipped or repeated.
REQ-019 Transfer of nibble index 0 SHALL return to IDLE (or enter CR per REQ-025); index does not wrap.
REQ-020 With out_ready held 1, a word SHALL take exactly NIBBLES cycles in SEND; the next accept occurs no earlier than the following IDLE cycle.
REQ-021 in_valid asserted while not in IDLE SHALL be ignored; captured word unaffected.
REQ-022 out_valid SHALL be 0 and out_char SHALL be 0 in IDLE.

Reset
REQ-023 rst_n low SHALL immediately force state IDLE, index 0, word register 0, out_valid 0, out_char 0, busy 0, in_ready 1.
REQ-024 Reset asserted mid-word SHALL abandon the word; after release, no remaining characters of that word are emitted.

Configuration
REQ-025 Macro HEX_STREAM_CRLF_EN defined: after the index-0 transfer SHALL enter CR (out_char 0x0D), then LF (out_char 0x0A), each held until transferred, then IDLE; busy stays 1 throughout.
REQ-026 Macro HEX_STREAM_CRLF_EN undefined: CR/LF states and logic SHALL be absent; the index-0 transfer goes directly to IDLE.

Verification
REQ-027 NIBBLES=4, in_data 0x1A2F, out_ready=1 -> out_char 0x31, 0x41, 0x32, 0x46 on four consecutive cycles, then IDLE with in_ready=1.
REQ-028 in_data 0x0000 then 0xFFFF -> four 0x30, then four 0x46; no gap characters between words.
REQ-029 in_data 0x9B3C, out_ready low for 3 cycles during the second character -> 0x42 held stable for 3 cycles; final stream 0x39, 0x42, 0x33, 0x43.
REQ-030 in_valid pulsed with 0x5555 during streaming of 0x1234 -> only 0x31..0x34 emitted; 0x5555 not accepted.
REQ-031 rst_n low after the second character of 0x1234 -> outputs zero asynchronously; after release, in_ready=1 and no 0x33/0x34 emitted.
REQ-032 HEX_STREAM_CRLF_EN defined, in_data 0x00AB -> 0x30, 0x30, 0x41, 0x42, 0x0D, 0x0A, then IDLE.
